instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  IF stage of the single-issue MIPS pipeline. Holds the program counter (PC) and drives
//  instruction_address into instruction_memory (combinational read). Latches the returned
//  word into the IF/ID pipeline register. Takes stall, flush and branch/jump redirects
//  from the ID stage, and squashes wrong-path fetches.
// PARAMETERS
//  ADDR_WIDTH  5   PC / word-address width (matches the instruction_memory depth, 32 words)
//  DATA_WIDTH  32  instruction width
//  RESET_PC    0   PC value loaded on reset
// PORTS
//  clk               in   1           rising-edge clock
//  reset             in   1           asynchronous, active-high reset
//  stall             in   1           hold PC and IF/ID (load-use hazard)
//  flush             in   1           bubble IF/ID; PC still advances
//  branch_taken      in   1           ID resolved a taken branch (instr in IF/ID)
//  branch_offset     in   16          signed word offset, relative to if_id_pc+1
//  jump              in   1           ID holds a J-type jump
//  jump_index        in   26          jump target word index
//  instruction_address out ADDR_WIDTH to instruction_memory (== PC)
//  instruction       in   DATA_WIDTH  word from instruction_memory
//  if_id_instruction out  DATA_WIDTH  latched instruction (0 = NOP when bubble)
//  if_id_pc          out  ADDR_WIDTH  PC of latched instruction
//  if_id_valid       out  1           IF/ID holds a real instruction
//  halted            out  1           fetch halted (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, any time, including mid-redirect): PC=RESET_PC, if_id_instruction=0,
//    if_id_pc=0, if_id_valid=0, halted=0. Takes effect immediately; no pending redirect survives.
//  - instruction_address = PC at all times (combinational from the PC register).
//  - Latency: a word fetched while PC=A appears on if_id_* after the next rising edge.
//  - Per-edge priority (non-reset):
//    1 stall=1: PC and all if_id_* hold. flush/branch_taken/jump are ignored this cycle.
//      ID must re-present them.
//    2 redirect (valid only if if_id_valid=1; otherwise ignored). jump beats branch_taken:
//      jump:   PC <= jump_index[ADDR_WIDTH-1:0]
//      branch: PC <= if_id_pc + 1 + branch_offset[ADDR_WIDTH-1:0]
//        (sum modulo 2^ADDR_WIDTH)
//      IF/ID <= bubble (instr=0, pc=0, valid=0): squashes the wrong-path word.
//    3 flush=1 (no redirect): IF/ID <= bubble; PC <= PC+1.
//    4 normal: IF/ID <= {instruction, PC, valid=1}; PC <= PC+1.
//  - Wrap-around: PC = 2^ADDR_WIDTH-1 increments to 0. Branch targets wrap the same way.
//  - Out of reset, the first edge captures mem[RESET_PC] with valid=1.
//  - Redirects are 1-cycle penalty: exactly one bubble per taken branch or jump.
// CONFIGURATION
//  FETCH_HALT_EN defined:
//   - A word with instruction[31:26]==6'b111111 is latched normally (case 4).
//     On the same edge, halted <= 1.
//   - While halted=1: PC frozen; every edge loads a bubble; stall, flush and redirects
//     are ignored.
//   - Only reset clears halted.
//   - A halt word fetched on a wrong path that is squashed in the same edge
//     (case 2 or 3) does not halt.
//  FETCH_HALT_EN undefined: halted tied 0; opcode 6'b111111 is fetched like any other word.
// TESTING
//  T1 reset, mem[i]=i+0x100: release reset -> instruction_address 0,1,2,...;
//     if_id_instruction 0x100,0x101,... one cycle behind; if_id_valid=1 from the first edge.
//  T2 free-run to PC=31 -> next instruction_address=0; if_id_pc 31 then 0.
//  T3 stall held 3 cycles at PC=5 -> PC stays 5, if_id_* unchanged; resumes 6 after
//     release. flush raised during the stall is ignored.
//  T4 branch_taken with if_id_pc=4, offset=-3 (0xFFFD) -> PC=2 next edge; one bubble
//     (valid=0, instr=0); then mem[2]. Same with if_id_pc=30, offset=+5 -> PC=4 (wrap).
//  T5 jump=1 and branch_taken=1 together, jump_index=9 -> PC=9 (jump wins); one bubble.
//     Redirect with if_id_valid=0 -> ignored, PC+1.
//  T6 FETCH_HALT_EN, mem[3]=0xFC000000 -> latched at if_id_pc=3, halted=1; PC frozen at 4;
//     bubbles follow. Assert reset mid-run -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: ID-stage control, instruction memory port and IF/ID register outputs.
interface instruction_fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  stall;
    logic                  flush;
    logic                  branch_taken;
    logic [15:0]           branch_offset;
    logic                  jump;
    logic [25:0]           jump_index;
    logic [ADDR_WIDTH-1:0] instruction_address;
    logic [DATA_WIDTH-1:0] instruction;
    logic [DATA_WIDTH-1:0] if_id_instruction;
    logic [ADDR_WIDTH-1:0] if_id_pc;
    logic                  if_id_valid;
    logic                  halted;

    // Pipeline/memory side driving the fetch unit
    modport master (
        output stall, flush, branch_taken, branch_offset, jump, jump_index, instruction,
        input  instruction_address, if_id_instruction, if_id_pc, if_id_valid, halted
    );

    // Fetch unit itself
    modport slave (
        input  stall, flush, branch_taken, branch_offset, jump, jump_index, instruction,
        output instruction_address, if_id_instruction, if_id_pc, if_id_valid, halted
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// IF stage: program counter, IF/ID register, stall/flush/redirect handling.
// Optional macro FETCH_HALT_EN: opcode 6'b111111 halts fetch until reset.
module instruction_fetch_unit #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    instruction_fetch_unit_if.slave bus
);
    localparam int unsigned AW = ADDR_WIDTH;
    localparam int unsigned DW = DATA_WIDTH;

    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_if_id_pc;
    logic [DW-1:0] r_if_id_instruction;
    logic          r_if_id_valid;
    logic          r_halted;

    // Redirects only count when ID actually holds a real instruction
    wire           w_redirect      = r_if_id_valid & (bus.jump | bus.branch_taken);
    wire  [AW-1:0] w_branch_target = r_if_id_pc + AW'(1) + bus.branch_offset[AW-1:0];
    wire  [AW-1:0] w_redirect_pc   = bus.jump ? bus.jump_index[AW-1:0] : w_branch_target;

`ifdef FETCH_HALT_EN
    wire           w_halt_word     = (bus.instruction[31:26] == 6'b111111);
`else
    wire           w_halt_word     = 1'b0;
`endif

    // Upper offset/index bits are architecturally dropped by the narrow PC
    wire           w_unused = ^{bus.branch_offset[15:AW], bus.jump_index[25:AW], w_halt_word};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc                <= AW'(RESET_PC);
            r_if_id_pc          <= '0;
            r_if_id_instruction <= '0;
            r_if_id_valid       <= 1'b0;
            r_halted            <= 1'b0;
        end else if (r_halted) begin
            r_if_id_pc          <= '0;
            r_if_id_instruction <= '0;
            r_if_id_valid       <= 1'b0;
        end else if (bus.stall) begin
            r_pc                <= r_pc;
        end else if (w_redirect) begin
            r_pc                <= w_redirect_pc;
            r_if_id_pc          <= '0;
            r_if_id_instruction <= '0;
            r_if_id_valid       <= 1'b0;
        end else if (bus.flush) begin
            r_pc                <= r_pc + AW'(1);
            r_if_id_pc          <= '0;
            r_if_id_instruction <= '0;
            r_if_id_valid       <= 1'b0;
        end else begin
            r_pc                <= r_pc + AW'(1);
            r_if_id_pc          <= r_pc;
            r_if_id_instruction <= bus.instruction;
            r_if_id_valid       <= 1'b1;
            r_halted            <= w_halt_word;
        end
    end

    assign bus.instruction_address = r_pc;
    assign bus.if_id_pc            = r_if_id_pc;
    assign bus.if_id_instruction   = r_if_id_instruction;
    assign bus.if_id_valid         = r_if_id_valid;
    assign bus.halted              = r_halted;
endmodule
